// File: rtl/present_decryptor_top.sv
// Iterative PRESENT-80 decryptor: one inverse round per clock, inverse key schedule on the fly.
// A key load runs the forward schedule once and keeps the final-round key for every block.
module present_decryptor_top #(
    parameter int NUM_ROUNDS = 31
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [79:0] data_i,
    input  logic        key_load,
    input  logic        data_load,
    output logic [63:0] data_o,
    output logic        key_ready,
    output logic        busy,
    output logic        data_valid
);

    typedef enum logic [2:0] {IDLE, EXPAND, READY, DECRYPT, DONE} fsm_t;

    localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS);

    fsm_t        fsm_q, fsm_d;
    logic [79:0] key_q, key_d, key_last_q, key_last_d;
    logic [63:0] blk_q, blk_d, data_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        key_ready_d, busy_d, valid_d;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
            4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
            4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
        endcase
        return y;
    endfunction

    // Forward step: rotl61, S-box on top nibble, round counter into bits [19:15].
    logic [79:0] key_rot, key_fwd, key_mix, key_inv;
    assign key_rot = {key_q[18:0], key_q[79:19]};
    assign key_fwd = {sbox(key_rot[79:76]), key_rot[75:20], key_rot[19:15] ^ cnt_q, key_rot[14:0]};

    // Inverse step undoes the forward step in reverse order; the two field edits are disjoint.
    assign key_mix = {inv_sbox(key_q[79:76]), key_q[75:20], key_q[19:15] ^ cnt_q, key_q[14:0]};
    assign key_inv = {key_mix[60:0], key_mix[79:61]};

    logic [63:0] mix, perm, round_out;
    assign mix = blk_q ^ key_q[79:16];

    for (genvar g = 0; g < 63; g++) begin : g_inv_perm
        assign perm[g] = mix[(16 * g) % 63];
    end
    assign perm[63] = mix[63];

    for (genvar n = 0; n < 16; n++) begin : g_inv_sbox
        assign round_out[4*n +: 4] = inv_sbox(perm[4*n +: 4]);
    end

    // key_load wins over everything else in every state.
    always_comb begin
        fsm_d       = fsm_q;
        key_d       = key_q;
        key_last_d  = key_last_q;
        blk_d       = blk_q;
        cnt_d       = cnt_q;
        data_d      = data_o;
        key_ready_d = key_ready;
        busy_d      = busy;
        valid_d     = data_valid;
        if (key_load) begin
            key_d       = data_i;
            cnt_d       = 5'd1;
            fsm_d       = EXPAND;
            key_ready_d = 1'b0;
            valid_d     = 1'b0;
            busy_d      = 1'b1;
        end else begin
            case (fsm_q)
                EXPAND: begin
                    key_d = key_fwd;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == LAST_ROUND) begin
                        key_last_d  = key_fwd;
                        cnt_d       = '0;
                        fsm_d       = READY;
                        key_ready_d = 1'b1;
                        busy_d      = 1'b0;
                    end
                end
                READY, DONE: begin
                    if (data_load) begin
                        blk_d   = data_i[63:0];
                        key_d   = key_last_q;
                        cnt_d   = LAST_ROUND;
                        fsm_d   = DECRYPT;
                        busy_d  = 1'b1;
                        valid_d = 1'b0;
                    end
                end
                DECRYPT: begin
                    blk_d = round_out;
                    key_d = key_inv;
                    cnt_d = cnt_q - 5'd1;
                    // After the round-1 inverse update the key register again holds K1 on top.
                    if (cnt_q == 5'd1) begin
                        data_d  = round_out ^ key_inv[79:16];
                        fsm_d   = DONE;
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
                IDLE:    fsm_d = IDLE;
                default: fsm_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q      <= IDLE;
            key_q      <= '0;
            key_last_q <= '0;
            blk_q      <= '0;
            cnt_q      <= '0;
            data_o     <= '0;
            key_ready  <= 1'b0;
            busy       <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            key_q      <= key_d;
            key_last_q <= key_last_d;
            blk_q      <= blk_d;
            cnt_q      <= cnt_d;
            data_o     <= data_d;
            key_ready  <= key_ready_d;
            busy       <= busy_d;
            data_valid <= valid_d;
        end
    end

endmodule

// File: tb/tb_present_decryptor_top.sv
// Scoreboard bench for present_decryptor_top: expected plaintexts are queued at load time
// and popped by a monitor whenever data_valid rises.
module tb_present_decryptor_top;

    logic        clk;
    logic        rst_i;
    logic [79:0] data_i;
    logic        key_load;
    logic        data_load;
    logic [63:0] data_o;
    logic        key_ready;
    logic        busy;
    logic        data_valid;

    int total = 0;
    int bad   = 0;
    logic [63:0] expQ[$];
    logic        prevValid = 1'b0;

    localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                         4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    present_decryptor_top #(.NUM_ROUNDS(31)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .data_i    (data_i),
        .key_load  (key_load),
        .data_load (data_load),
        .data_o    (data_o),
        .key_ready (key_ready),
        .busy      (busy),
        .data_valid(data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference PRESENT-80 encryption; random blocks are built as ciphertexts of known plaintexts.
    function automatic logic [63:0] presentEncrypt(input logic [79:0] key, input logic [63:0] pt);
        logic [79:0] k;
        logic [63:0] s, t;
        int dst;
        k = key;
        s = pt;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            t = '0;
            for (int n = 0; n < 16; n++)
                t = t | (64'(SBOX[4'(s >> (4 * n))]) << (4 * n));
            s = t;
            t = '0;
            for (int b = 0; b < 64; b++) begin
                dst = (b == 63) ? 63 : (16 * b) % 63;
                t = t | (((s >> b) & 64'd1) << dst);
            end
            s = t;
            k = {k[18:0], k[79:19]};
            k[79:76] = SBOX[k[79:76]];
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    always @(negedge clk) begin
        if (data_valid && !prevValid) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_valid actual=%h required=none", data_o);
            end else begin
                checkOutput("data_o", data_o, expQ.pop_front());
            end
        end
        prevValid = data_valid;
    end

    task automatic loadKey(input logic [79:0] k, input int injectAt);
        @(negedge clk);
        data_i   = k;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            if (i == injectAt) begin
                data_load = 1'b1;
                data_i    = {16'($urandom), $urandom, $urandom};
            end
            @(negedge clk);
            data_load = 1'b0;
            if (i == 30) checkOutput("key_ready_early", 64'(key_ready), 64'd0);
        end
        checkOutput("key_ready_at_31", 64'(key_ready), 64'd1);
        checkOutput("busy_after_expand", 64'(busy), 64'd0);
    endtask

    task automatic applyStimulus(input logic [63:0] ct, input logic [63:0] expected, input int injectAt);
        int busyCycles;
        @(negedge clk);
        data_i    = {16'h0, ct};
        data_load = 1'b1;
        expQ.push_back(expected);
        @(negedge clk);
        data_load  = 1'b0;
        busyCycles = 0;
        for (int i = 1; i <= 31; i++) begin
            if (busy) busyCycles++;
            if (i == injectAt) begin
                data_load = 1'b1;
                data_i    = {16'($urandom), $urandom, $urandom};
            end
            @(negedge clk);
            data_load = 1'b0;
        end
        checkOutput("busy_cycles", 64'(busyCycles), 64'd31);
        checkOutput("busy_low_after", 64'(busy), 64'd0);
        checkOutput("data_valid_at_31", 64'(data_valid), 64'd1);
    endtask

    task automatic startUnchecked(input logic [63:0] ct);
        @(negedge clk);
        data_i    = {16'h0, ct};
        data_load = 1'b1;
        @(negedge clk);
        data_load = 1'b0;
    endtask

    initial begin
        logic [79:0] rk;
        logic [63:0] pt;
        rst_i     = 1'b1;
        key_load  = 1'b0;
        data_load = 1'b0;
        data_i    = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_data_o", data_o, 64'd0);
        checkOutput("reset_data_valid", 64'(data_valid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_key_ready", 64'(key_ready), 64'd0);
        rst_i = 1'b0;

        loadKey(80'h0, 0);
        applyStimulus(64'h5579C1387B228445, 64'h0000000000000000, 0);

        loadKey({80{1'b1}}, 0);
        applyStimulus(64'h3333DCD3213210D2, 64'hFFFFFFFFFFFFFFFF, 0);
        applyStimulus(64'hE72C46C0F5945049, 64'h0000000000000000, 0);

        // Stray data_load pulses during expansion and mid-block must be ignored.
        loadKey(80'h0, 5);
        applyStimulus(64'hA112FFC72F68417B, 64'hFFFFFFFFFFFFFFFF, 12);
        repeat (4) @(negedge clk);
        checkOutput("done_hold_data_o", data_o, 64'hFFFFFFFFFFFFFFFF);
        checkOutput("done_hold_valid", 64'(data_valid), 64'd1);

        startUnchecked(64'h5579C1387B228445);
        repeat (10) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        checkOutput("rst_mid_data_o", data_o, 64'd0);
        checkOutput("rst_mid_valid", 64'(data_valid), 64'd0);
        checkOutput("rst_mid_busy", 64'(busy), 64'd0);
        checkOutput("rst_mid_key_ready", 64'(key_ready), 64'd0);
        startUnchecked(64'h5579C1387B228445);
        repeat (5) @(negedge clk);
        checkOutput("idle_load_busy", 64'(busy), 64'd0);
        checkOutput("idle_load_valid", 64'(data_valid), 64'd0);
        checkOutput("idle_load_key_ready", 64'(key_ready), 64'd0);

        // key_load together with data_load mid-block: key wins, block is dropped.
        loadKey({80{1'b1}}, 0);
        startUnchecked(64'hE72C46C0F5945049);
        repeat (10) @(negedge clk);
        data_i    = 80'h0;
        key_load  = 1'b1;
        data_load = 1'b1;
        @(negedge clk);
        key_load  = 1'b0;
        data_load = 1'b0;
        checkOutput("abort_valid", 64'(data_valid), 64'd0);
        checkOutput("abort_busy", 64'(busy), 64'd1);
        checkOutput("abort_key_ready", 64'(key_ready), 64'd0);
        repeat (30) @(negedge clk);
        checkOutput("reexpand_early", 64'(key_ready), 64'd0);
        @(negedge clk);
        checkOutput("reexpand_at_31", 64'(key_ready), 64'd1);
        applyStimulus(64'h5579C1387B228445, 64'h0000000000000000, 0);

        for (int kIdx = 0; kIdx < 4; kIdx++) begin
            rk = {16'($urandom), $urandom, $urandom};
            loadKey(rk, 0);
            for (int b = 0; b < 3; b++) begin
                pt = {$urandom, $urandom};
                applyStimulus(presentEncrypt(rk, pt), pt, 0);
            end
        end

        repeat (2) @(negedge clk);
        checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/present_decryptor_top.md
Name: present_decryptor_top

Overview:
- Iterative PRESENT-80 decryption core that inverts the team's encryption core: ciphertext in, plaintext out.
- One round per clock, with on-the-fly inverse key schedule.
- Because decryption starts from the last round key, a key load triggers a 31-cycle forward key expansion. The core stores the resulting final-round key register and restores it for each block, so back-to-back blocks under one key need no re-expansion.
- Sits beside the encryptor and shares the data_i/key_load/data_load loading convention.

Parameters:
- NUM_ROUNDS, 31: number of PRESENT rounds; fixed for PRESENT-80. The round counter is 5 bits.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  synchronous, active-high reset
- data_i  input  80  key (all 80 bits) or ciphertext (bits [63:0])
- key_load  input  1  when 1, load data_i as key and start expansion
- data_load  input  1  when 1 and the core is ready, load data_i[63:0] as ciphertext
- data_o  output  64  registered plaintext
- key_ready  output  1  expanded key available; ciphertext may be loaded
- busy  output  1  expansion or decryption in progress
- data_valid  output  1  data_o holds the plaintext for the last accepted block

Behaviour:
- Reset (rst_i=1 at an edge): FSM to IDLE; key_ready=0, busy=0, data_valid=0, data_o=0, counter=0.
- Reset overrides key_load and data_load and aborts any operation mid-flight.
- FSM states are IDLE, EXPAND, READY, DECRYPT, DONE.
- key_load has priority over data_load in every state, including mid-EXPAND and mid-DECRYPT. At that edge:
  - key <= data_i; counter <= 1; go to EXPAND.
  - key_ready <= 0, data_valid <= 0, busy <= 1.
- EXPAND, forward update each cycle with r = counter:
  - key <= rotl61(key).
  - Then bits [79:76] <= S(bits [79:76]).
  - Then bits [19:15] ^= r.
  - counter++.
  - On the edge with r=31: key_last <= updated key; go to READY; key_ready <= 1; busy <= 0.
  - Total: key_ready rises exactly 31 edges after the key_load edge.
- data_load in READY or DONE (key_load=0):
  - state <= data_i[63:0]; key <= key_last; counter <= 31.
  - Go to DECRYPT; busy <= 1; data_valid <= 0.
- data_load in IDLE, EXPAND or DECRYPT is ignored; no state change.
- DECRYPT, each edge with r = counter:
  - state <= invS(invP(state ^ key[79:16])).
  - Inverse key update: bits [19:15] ^= r; then bits [79:76] <= invS(bits [79:76]); then key <= rotr61(key).
  - counter--.
  - On the edge with r=1: data_o <= invS(invP(state ^ key[79:16])) ^ K1, where K1 is bits [79:16] of the inverse-updated key (this equals the original key's top 64 bits).
  - At the same edge: go to DONE; data_valid <= 1; busy <= 0.
  - Latency: data_valid rises 31 edges after the data_load edge.
- DONE:
  - data_o and data_valid hold until the next accepted data_load or a key_load.
  - key_ready stays 1.
- Inverse layers:
  - invP: output bit i comes from input bit P(i), where P(i) = 16i mod 63 for i<63 and P(63) = 63.
  - invS is the inverse of the PRESENT S-box; the inverse S-box is C→0, 5→1, 6→2, B→3, 9→4, 0→5, A→6, D→7, 3→8, E→9, F→A, 8→B, 4→C, 7→D, 1→E, 2→F.
- data_i is sampled only at load edges. Counter arithmetic is unsigned 5-bit with no wrap in normal flow.

Test Plan:
- Reset, then key_load of 0x0, 31 idle cycles, data_load of 0x5579C1387B228445 -> key_ready=1 at edge 31; data_valid=1 after 31 more edges; data_o=0x0000000000000000.
- key 0xFFFFFFFFFFFFFFFFFFFF, ciphertext 0x3333DCD3213210D2 -> data_o=0xFFFFFFFFFFFFFFFF. Then a second block 0xE72C46C0F5945049 loaded from DONE without a key reload -> data_o=0x0000000000000000.
- key 0x0, ciphertext 0xA112FFC72F68417B -> data_o=0xFFFFFFFFFFFFFFFF; busy is high for exactly 31 cycles.
- data_load asserted during EXPAND and mid-DECRYPT -> ignored; the in-flight result is unchanged and data_o is correct.
- key_load asserted mid-DECRYPT together with data_load -> data_valid=0, re-expansion starts, data_load is dropped; key_ready returns after 31 edges.
- rst_i pulsed mid-DECRYPT -> the following cycle all outputs are 0 and the FSM is IDLE; a subsequent data_load is ignored until a key has been loaded.
